riscv_mem_arb: RTL and testbench

//  Shares one BIU memory port between the instruction-fetch port (imem) and the EX-stage

---
 rtl/riscv_mem_arb.sv | 112 +++++++++++
 tb/tb_riscv_mem_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arb.sv
// Arbiter that shares one BIU port between instruction fetch and data load/store.
// Data has priority, fetch is guarded against starvation, and the bus can be aborted on timeout.
module riscv_mem_arb #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_adr,
  input  logic            imem_flush,
  output logic            imem_ack,
  output logic [XLEN-1:0] imem_q,
  output logic            imem_err,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic [2:0]      dmem_size,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_err,
  output logic            biu_req,
  output logic            biu_we,
  output logic [XLEN-1:0] biu_adr,
  output logic [XLEN-1:0] biu_d,
  output logic [2:0]      biu_size,
  input  logic            biu_ack,
  input  logic [XLEN-1:0] biu_q,
  input  logic            biu_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] SizeWord = 3'b010;

  typedef enum logic [1:0] {StIdle, StIbusy, StDbusy} state_e;

  state_e        state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          drop;

  logic imem_live, imem_forced, grant_d, grant_i, busy, tmo_hit, done;

  always_comb begin
    imem_live   = imem_req && !imem_flush;
    imem_forced = imem_live && (starve_cnt == SW'(STARVE_LIMIT));
    grant_d     = (state == StIdle) && dmem_req && !imem_forced;
    grant_i     = (state == StIdle) && !grant_d && imem_live;
    busy        = (state != StIdle);
    // tmo_cnt counts completed busy cycles, so the abort lands on busy cycle number TIMEOUT
    tmo_hit     = (TIMEOUT != 0) && busy && !biu_ack && (tmo_cnt == TW'(TIMEOUT - 1));
    done        = busy && (biu_ack || tmo_hit);
    biu_req     = busy;

    imem_ack = (state == StIbusy) && done && !drop && !imem_flush;
    imem_q   = (imem_ack && biu_ack) ? biu_q : '0;
    imem_err = imem_ack && (!biu_ack || biu_err);

    dmem_ack = (state == StDbusy) && done;
    dmem_q   = (dmem_ack && biu_ack) ? biu_q : '0;
    dmem_err = dmem_ack && (!biu_ack || biu_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      drop       <= 1'b0;
      biu_we     <= 1'b0;
      biu_adr    <= '0;
      biu_d      <= '0;
      biu_size   <= '0;
    end else begin
      case (state)
        StIdle: begin
          tmo_cnt <= '0;
          drop    <= 1'b0;
          if (grant_d) begin
            state    <= StDbusy;
            biu_we   <= dmem_we;
            biu_adr  <= dmem_adr;
            biu_d    <= dmem_d;
            biu_size <= dmem_size;
            if (imem_live && (starve_cnt != SW'(STARVE_LIMIT))) starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_i) begin
            state    <= StIbusy;
            biu_we   <= 1'b0;
            biu_adr  <= imem_adr;
            biu_d    <= '0;
            biu_size <= SizeWord;
          end
          if (!imem_req || grant_i) starve_cnt <= '0;
        end
        StIbusy, StDbusy: begin
          if (done) begin
            state <= StIdle;
            drop  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if ((state == StIbusy) && imem_flush) drop <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Bench for riscv_mem_arb: directed scenarios plus random traffic, all outputs checked each
// cycle against a transaction-level model of the arbiter.
module tb_riscv_mem_arb;

  localparam int XLEN = 32;
  localparam int SL   = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req, imem_flush, imem_ack, imem_err;
  logic [XLEN-1:0] imem_adr, imem_q;
  logic            dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [XLEN-1:0] dmem_adr, dmem_d, dmem_q;
  logic [2:0]      dmem_size;
  logic            biu_req, biu_we, biu_ack, biu_err;
  logic [XLEN-1:0] biu_adr, biu_d, biu_q;
  logic [2:0]      biu_size;

  always #5 clk = ~clk;

  riscv_mem_arb #(.XLEN(XLEN), .STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_adr(imem_adr), .imem_flush(imem_flush),
    .imem_ack(imem_ack), .imem_q(imem_q), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_d(dmem_d),
    .dmem_size(dmem_size), .dmem_ack(dmem_ack), .dmem_q(dmem_q), .dmem_err(dmem_err),
    .biu_req(biu_req), .biu_we(biu_we), .biu_adr(biu_adr), .biu_d(biu_d),
    .biu_size(biu_size), .biu_ack(biu_ack), .biu_q(biu_q), .biu_err(biu_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: owner 0 = none, 1 = fetch, 2 = data; m_cyc = index of the current busy cycle.
  int          m_own, m_starve, m_cyc;
  bit          m_drop;
  logic        m_we;
  logic [31:0] m_adr, m_d;
  logic [2:0]  m_size;
  logic        e_iack, e_ierr, e_dack, e_derr, e_breq;
  logic [31:0] e_iq, e_dq;
  logic [9:0]  gvec;
  int          gcnt;
  int          k;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_starve = 0; m_cyc = 0; m_drop = 0;
    m_we = 0; m_adr = 0; m_d = 0; m_size = 0;
  endtask

  task automatic model_cycle();
    bit tmo_fire, fin, live;
    if (rst) model_reset();
    e_iack = 0; e_ierr = 0; e_iq = 0; e_dack = 0; e_derr = 0; e_dq = 0;
    e_breq   = (m_own != 0);
    tmo_fire = (TMO != 0) && (m_own != 0) && !biu_ack && (m_cyc == TMO);
    fin      = (m_own != 0) && (biu_ack || tmo_fire);
    if (fin && m_own == 1 && !m_drop && !imem_flush) begin
      e_iack = 1; e_iq = biu_ack ? biu_q : 32'h0; e_ierr = biu_ack ? biu_err : 1'b1;
    end
    if (fin && m_own == 2) begin
      e_dack = 1; e_dq = biu_ack ? biu_q : 32'h0; e_derr = biu_ack ? biu_err : 1'b1;
    end

    check1("imem_ack", imem_ack, e_iack);
    check32("imem_q", imem_q, e_iq);
    check1("imem_err", imem_err, e_ierr);
    check1("dmem_ack", dmem_ack, e_dack);
    check32("dmem_q", dmem_q, e_dq);
    check1("dmem_err", dmem_err, e_derr);
    check1("biu_req", biu_req, e_breq);
    check1("biu_we", biu_we, m_we);
    check32("biu_adr", biu_adr, m_adr);
    check32("biu_d", biu_d, m_d);
    check32("biu_size", {29'b0, biu_size}, {29'b0, m_size});

    if (!rst) begin
      if (m_own != 0) begin
        if (fin) begin
          m_own = 0; m_drop = 0;
        end else begin
          m_cyc++;
          if (m_own == 1 && imem_flush) m_drop = 1;
        end
      end else begin
        live = imem_req && !imem_flush;
        if (dmem_req && !(live && m_starve == SL)) begin
          m_own = 2; m_cyc = 1;
          m_we = dmem_we; m_adr = dmem_adr; m_d = dmem_d; m_size = dmem_size;
          gvec = {gvec[8:0], 1'b0}; gcnt++;
          if (live && m_starve < SL) m_starve++;
        end else if (live) begin
          m_own = 1; m_cyc = 1;
          m_we = 0; m_adr = imem_adr; m_d = 0; m_size = 3'b010;
          gvec = {gvec[8:0], 1'b1}; gcnt++;
          m_starve = 0;
        end
        if (!imem_req) m_starve = 0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; imem_req = 0; imem_adr = 0; imem_flush = 0;
    dmem_req = 0; dmem_we = 0; dmem_adr = 0; dmem_d = 0; dmem_size = 0;
    biu_ack = 0; biu_q = 0; biu_err = 0;
    gvec = 0; gcnt = 0;
    model_reset();
    sample();
    check1("reset biu_req", biu_req, 1'b0);
    check32("reset biu_adr", biu_adr, 32'h0);
    advance();
    rst = 0;

    // 1: lone load, ack three cycles after biu_req rises
    dmem_req = 1; dmem_we = 0; dmem_adr = 32'h100; dmem_size = 3'b010;
    step();
    sample(); check1("t1 biu_req N+1", biu_req, 1'b1); advance();
    step(); step();
    biu_ack = 1; biu_q = 32'hCAFEF00D;
    sample();
    check1("t1 dmem_ack", dmem_ack, 1'b1);
    check1("t1 model ack", e_dack, 1'b1);
    check32("t1 dmem_q", dmem_q, 32'hCAFEF00D);
    check32("t1 biu_adr", biu_adr, 32'h100);
    check1("t1 imem_ack", imem_ack, 1'b0);
    advance();
    dmem_req = 0; biu_ack = 0;
    step();

    // 2: continuous contention, immediate bus ack
    gvec = 0; gcnt = 0;
    imem_req = 1; imem_adr = 32'h400;
    dmem_req = 1; dmem_we = 1; dmem_adr = 32'h800; dmem_d = 32'h1234; dmem_size = 3'b010;
    biu_ack = 1; biu_q = 32'h5A5A0000;
    k = 0;
    while (gcnt < 10 && k < 40) begin step(); k++; end
    check32("t2 grant count", gcnt, 10);
    check32("t2 grant order", {22'b0, gvec}, 32'b00_0010_0001);
    step();
    imem_req = 0;
    step(); step();
    dmem_req = 0; biu_ack = 0;
    step();

    // 3: fetch flushed in flight, pending load follows after the bubble
    imem_req = 1; imem_adr = 32'h40;
    step();
    imem_flush = 1; imem_req = 0;
    dmem_req = 1; dmem_we = 0; dmem_adr = 32'h300; dmem_size = 3'b001;
    step();
    imem_flush = 0;
    step();
    biu_ack = 1; biu_q = 32'h11112222;
    sample();
    check1("t3 dropped ack", imem_ack, 1'b0);
    check1("t3 model drop", e_iack, 1'b0);
    advance();
    biu_ack = 0;
    sample(); check1("t3 bubble", biu_req, 1'b0); advance();
    sample();
    check1("t3 d granted", biu_req, 1'b1);
    check32("t3 d adr", biu_adr, 32'h300);
    advance();
    biu_ack = 1;
    step();
    dmem_req = 0; biu_ack = 0;
    step();

    // 4: store with no bus response aborts on busy cycle 8
    dmem_req = 1; dmem_we = 1; dmem_adr = 32'h200; dmem_d = 32'hA5A5; dmem_size = 3'b010;
    step();
    k = 1;
    sample();
    while (!dmem_ack && k < 20) begin advance(); k++; sample(); end
    check32("t4 timeout cycle", k, 8);
    check1("t4 dmem_err", dmem_err, 1'b1);
    check32("t4 dmem_q", dmem_q, 32'h0);
    advance();
    dmem_req = 0;
    sample(); check1("t4 biu_req drop", biu_req, 1'b0); advance();
    biu_ack = 1; biu_q = 32'hDEAD;
    sample(); check1("t4 stray ack", dmem_ack, 1'b0); advance();
    biu_ack = 0;

    // 5: bus error on a fetch
    imem_req = 1; imem_adr = 32'h80;
    step();
    biu_ack = 1; biu_err = 1; biu_q = 32'h77;
    sample();
    check1("t5 imem_ack", imem_ack, 1'b1);
    check1("t5 imem_err", imem_err, 1'b1);
    advance();
    imem_req = 0; biu_ack = 0; biu_err = 0;
    step();

    // 6: asynchronous reset in the middle of a data transaction
    dmem_req = 1; dmem_we = 1; dmem_adr = 32'h900; dmem_d = 32'h42; dmem_size = 3'b000;
    step();
    rst = 1;
    #1;
    check1("t6 biu_req", biu_req, 1'b0);
    check32("t6 biu_adr", biu_adr, 32'h0);
    check1("t6 biu_we", biu_we, 1'b0);
    dmem_req = 0;
    sample();
    advance();
    rst = 0; biu_ack = 1;
    sample(); check1("t6 no ack", dmem_ack, 1'b0); advance();
    step();
    biu_ack = 0;

    // Random traffic honouring the requester handshake rules
    for (int i = 0; i < 4000; i++) begin
      if (imem_req && (e_iack || imem_flush)) imem_req = 0;
      else if (!imem_req && ($urandom % 3 == 0)) begin
        imem_req = 1; imem_adr = $urandom & 32'hFFFF_FFFC;
      end
      imem_flush = ($urandom % 10 == 0);
      if (dmem_req && e_dack) dmem_req = 0;
      else if (!dmem_req && ($urandom % 3 == 0)) begin
        dmem_req = 1; dmem_we = $urandom % 2 == 0; dmem_adr = $urandom; dmem_d = $urandom;
        dmem_size = 3'($urandom_range(0, 4));
      end
      biu_ack = ($urandom % 4 == 0);
      biu_q   = $urandom;
      biu_err = ($urandom % 8 == 0);
      rst     = ($urandom % 400 == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
